claw_game_ctrl: RTL and testbench

Game sequencer for the claw machine. It holds the coin credits and runs the play/claw state machine. It times each play window with the external mod-10 decade counter: it issues add/clear strobes to the counter and watches its count-9 flag. Sits between the coin/joystick/limit-switch inputs and the claw motor drivers.

---
 rtl/claw_game_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_claw_game_ctrl.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/claw_game_ctrl.sv
// claw_game_ctrl: claw machine game sequencer.
// Holds coin credits, runs the play/claw state machine and times the play
// window through an external mod-10 decade counter (add/clear strobes, count-9 flag).
// Optional motion watchdog: define CLAW_WDOG_EN.
module claw_game_ctrl #(
  parameter int unsigned CREDIT_W       = 4,
  parameter int unsigned COST           = 1,
  parameter int unsigned GRIP_CYCLES    = 8,
  parameter int unsigned RELEASE_CYCLES = 16,
  parameter int unsigned WDOG_CYCLES    = 1024
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                coin_i,
  input  logic                start_i,
  input  logic                left_i,
  input  logic                right_i,
  input  logic                drop_i,
  input  logic                tick_i,
  input  logic                down_lim_i,
  input  logic                up_lim_i,
  input  logic                home_lim_i,
  input  logic                cnt_done_i,
  output logic                cnt_add_o,
  output logic                cnt_clr_o,
  output logic [CREDIT_W-1:0] credits_o,
  output logic                motor_left_o,
  output logic                motor_right_o,
  output logic                motor_down_o,
  output logic                motor_up_o,
  output logic                grip_o,
  output logic                busy_o,
  output logic                fault_o,
  output logic [3:0]          state_o
);

  localparam int unsigned CREDIT_MAX = (2 ** CREDIT_W) - 1;
  localparam int unsigned SUM_W      = CREDIT_W + 1;
  // One shared interval timer, sized for the longest interval it can time
  localparam int unsigned TMR_GR     = (GRIP_CYCLES > RELEASE_CYCLES) ? GRIP_CYCLES : RELEASE_CYCLES;
  localparam int unsigned TMR_MAX    = (WDOG_CYCLES > TMR_GR) ? WDOG_CYCLES : TMR_GR;
  localparam int unsigned TMR_W      = $clog2(TMR_MAX + 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    READY   = 4'd1,
    PLAY    = 4'd2,
    DESCEND = 4'd3,
    GRIP    = 4'd4,
    ASCEND  = 4'd5,
    HOME    = 4'd6,
    RELEASE = 4'd7,
    FAULT   = 4'd8
  } state_t;

  state_t               state_q, state_d;
  logic [TMR_W-1:0]     timer_q;
  logic                 timer_run;
  logic                 game_start;
  logic                 add_d;
  logic                 coin_q, start_q, drop_q;
  logic                 coin_edge, start_edge, drop_edge;
  logic                 can_play;
  logic [SUM_W-1:0]     credit_sum;
  logic [CREDIT_W-1:0]  credits_d;

  assign coin_edge  = coin_i  & ~coin_q;
  assign start_edge = start_i & ~start_q;
  assign drop_edge  = drop_i  & ~drop_q;
  assign can_play   = (credits_o >= CREDIT_W'(COST));

  // Net credit change: +1 per coin edge, -COST on game start, saturating at max
  assign credit_sum = {1'b0, credits_o} + SUM_W'(coin_edge)
                      - (game_start ? SUM_W'(COST) : SUM_W'(0));
  assign credits_d  = (credit_sum > SUM_W'(CREDIT_MAX)) ? CREDIT_W'(CREDIT_MAX)
                                                        : credit_sum[CREDIT_W-1:0];

  // Edge history; reset high so levels held through reset are not edges
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      coin_q  <= 1'b1;
      start_q <= 1'b1;
      drop_q  <= 1'b1;
    end else begin
      coin_q  <= coin_i;
      start_q <= start_i;
      drop_q  <= drop_i;
    end
  end

  // State register and interval timer (restarts on every state change)
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) timer_q <= '0;
      else if (timer_run)     timer_q <= timer_q + TMR_W'(1);
    end
  end

  // Credits and decade-counter strobes
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      credits_o <= '0;
      cnt_add_o <= 1'b0;
      cnt_clr_o <= 1'b0;
    end else begin
      credits_o <= credits_d;
      cnt_add_o <= add_d;
      cnt_clr_o <= game_start;
    end
  end

  // Next-state logic and state-decoded motor/grip outputs
  always_comb begin
    state_d       = state_q;
    game_start    = 1'b0;
    add_d         = 1'b0;
    timer_run     = 1'b0;
    motor_left_o  = 1'b0;
    motor_right_o = 1'b0;
    motor_down_o  = 1'b0;
    motor_up_o    = 1'b0;
    grip_o        = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_play) state_d = READY;
      end
      READY: begin
        if (start_edge && can_play) begin
          state_d    = PLAY;
          game_start = 1'b1;
        end
      end
      PLAY: begin
        motor_left_o  = left_i & ~right_i;
        motor_right_o = right_i & ~left_i;
        // Drop beats tick; a tick during the clear cycle is ignored
        if (drop_edge) begin
          state_d = DESCEND;
        end else if (tick_i && !cnt_clr_o) begin
          if (cnt_done_i) state_d = DESCEND;
          else            add_d   = 1'b1;
        end
      end
      DESCEND: begin
        motor_down_o = 1'b1;
`ifdef CLAW_WDOG_EN
        timer_run = 1'b1;
        if (down_lim_i)                                state_d = GRIP;
        else if (timer_q == TMR_W'(WDOG_CYCLES - 1))   state_d = FAULT;
`else
        if (down_lim_i) state_d = GRIP;
`endif
      end
      GRIP: begin
        grip_o    = 1'b1;
        timer_run = 1'b1;
        if (timer_q == TMR_W'(GRIP_CYCLES - 1)) state_d = ASCEND;
      end
      ASCEND: begin
        grip_o     = 1'b1;
        motor_up_o = 1'b1;
`ifdef CLAW_WDOG_EN
        timer_run = 1'b1;
        if (up_lim_i)                                  state_d = HOME;
        else if (timer_q == TMR_W'(WDOG_CYCLES - 1))   state_d = FAULT;
`else
        if (up_lim_i) state_d = HOME;
`endif
      end
      HOME: begin
        grip_o       = 1'b1;
        motor_left_o = 1'b1;
`ifdef CLAW_WDOG_EN
        timer_run = 1'b1;
        if (home_lim_i)                                state_d = RELEASE;
        else if (timer_q == TMR_W'(WDOG_CYCLES - 1))   state_d = FAULT;
`else
        if (home_lim_i) state_d = RELEASE;
`endif
      end
      RELEASE: begin
        timer_run = 1'b1;
        if (timer_q == TMR_W'(RELEASE_CYCLES - 1)) state_d = IDLE;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o  = (state_q != IDLE) && (state_q != READY);
  assign state_o = state_q;

`ifdef CLAW_WDOG_EN
  assign fault_o = (state_q == FAULT);
`else
  assign fault_o = 1'b0;
`endif

endmodule

// File: tb/tb_claw_game_ctrl.sv
// tb_claw_game_ctrl: randomized self-checking bench for claw_game_ctrl.
// Credits and the decade counter are modelled in the bench; build with
// CLAW_WDOG_EN to exercise the watchdog (WDOG_CYCLES=32).
module tb_claw_game_ctrl;

  localparam int unsigned CREDIT_W = 4;
  localparam int unsigned COST     = 1;
  localparam int unsigned GRIP     = 8;
  localparam int unsigned REL      = 16;
`ifdef CLAW_WDOG_EN
  localparam int unsigned WDOG     = 32;
`else
  localparam int unsigned WDOG     = 1024;
`endif
  localparam int CMAX = (1 << CREDIT_W) - 1;

  localparam logic [3:0] S_IDLE = 4'd0, S_READY = 4'd1, S_PLAY = 4'd2, S_DESCEND = 4'd3,
                         S_GRIP = 4'd4, S_ASCEND = 4'd5, S_HOME = 4'd6, S_RELEASE = 4'd7,
                         S_FAULT = 4'd8;

  logic clk, Reset;
  logic coin_i, start_i, left_i, right_i, drop_i, tick_i;
  logic down_lim_i, up_lim_i, home_lim_i, cnt_done_i;
  logic cnt_add_o, cnt_clr_o;
  logic [CREDIT_W-1:0] credits_o;
  logic motor_left_o, motor_right_o, motor_down_o, motor_up_o, grip_o, busy_o, fault_o;
  logic [3:0] state_o;
  logic [4:0] mvec;

  int checks = 0;
  int errors = 0;
  int m_credits = 0;
  int dec_cnt = 0;
  int add_seen = 0;

  claw_game_ctrl #(
    .CREDIT_W(CREDIT_W), .COST(COST), .GRIP_CYCLES(GRIP),
    .RELEASE_CYCLES(REL), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .Reset(Reset), .coin_i(coin_i), .start_i(start_i), .left_i(left_i),
    .right_i(right_i), .drop_i(drop_i), .tick_i(tick_i), .down_lim_i(down_lim_i),
    .up_lim_i(up_lim_i), .home_lim_i(home_lim_i), .cnt_done_i(cnt_done_i),
    .cnt_add_o(cnt_add_o), .cnt_clr_o(cnt_clr_o), .credits_o(credits_o),
    .motor_left_o(motor_left_o), .motor_right_o(motor_right_o),
    .motor_down_o(motor_down_o), .motor_up_o(motor_up_o), .grip_o(grip_o),
    .busy_o(busy_o), .fault_o(fault_o), .state_o(state_o)
  );

  // {left, right, down, up, grip}
  assign mvec = {motor_left_o, motor_right_o, motor_down_o, motor_up_o, grip_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External mod-10 decade counter
  assign cnt_done_i = (dec_cnt == 9);
  always @(posedge clk or posedge Reset) begin
    if (Reset)          dec_cnt <= 0;
    else if (cnt_clr_o) dec_cnt <= 0;
    else if (cnt_add_o) dec_cnt <= (dec_cnt + 1) % 10;
  end

  // Running count of add strobes seen by the counter
  always @(posedge clk) if (cnt_add_o) add_seen <= add_seen + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic coin_lvl);
    Reset = 1'b1; coin_i = coin_lvl; start_i = 1'b0; left_i = 1'b0; right_i = 1'b0;
    drop_i = 1'b0; tick_i = 1'b0; down_lim_i = 1'b0; up_lim_i = 1'b0; home_lim_i = 1'b0;
    repeat (2) cyc();
    Reset = 1'b0;
    m_credits = 0;
    cyc();
  endtask

  task automatic coin_pulse();
    coin_i = 1'b1; cyc(); coin_i = 1'b0; cyc();
    m_credits = (m_credits + 1 > CMAX) ? CMAX : m_credits + 1;
  endtask

  task automatic test_reset();
    apply_reset(1'b1);
    repeat (3) cyc();
    checks++;
    if (state_o !== S_IDLE || credits_o !== '0) begin
      errors++; $display("FAIL reset_state: state=%0d credits=%0d want 0/0", state_o, credits_o);
    end
    checks++;
    if ({mvec, cnt_add_o, cnt_clr_o, busy_o, fault_o} !== 9'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 0", {mvec, cnt_add_o, cnt_clr_o, busy_o, fault_o});
    end
    coin_i = 1'b0; cyc();
    checks++;
    if (credits_o !== '0) begin
      errors++; $display("FAIL coin_held_through_reset: credits=%0d want 0", credits_o);
    end
    coin_pulse();
    checks++;
    if (credits_o !== CREDIT_W'(m_credits)) begin
      errors++; $display("FAIL first_coin: credits=%0d want %0d", credits_o, m_credits);
    end
  endtask

  task automatic test_credits_random();
    int n;
    apply_reset(1'b0);
    n = $urandom_range(3, 20);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) cyc();
      coin_pulse();
      checks++;
      if (credits_o !== CREDIT_W'(m_credits)) begin
        errors++; $display("FAIL credits_rand: coin %0d credits=%0d want %0d", i, credits_o, m_credits);
      end
    end
    checks++;
    if (state_o !== S_READY) begin
      errors++; $display("FAIL idle_to_ready: state=%0d want %0d", state_o, S_READY);
    end
  endtask

  task automatic test_saturation();
    apply_reset(1'b0);
    repeat (CMAX) coin_pulse();
    checks++;
    if (credits_o !== CREDIT_W'(CMAX)) begin
      errors++; $display("FAIL credits_full: credits=%0d want %0d", credits_o, CMAX);
    end
    coin_pulse();
    checks++;
    if (credits_o !== CREDIT_W'(CMAX)) begin
      errors++; $display("FAIL credits_saturate: credits=%0d want %0d", credits_o, CMAX);
    end
  endtask

  task automatic test_start();
    apply_reset(1'b0);
    coin_pulse(); coin_pulse();
    checks++;
    if (credits_o !== 4'd2 || state_o !== S_READY) begin
      errors++; $display("FAIL two_coins: credits=%0d state=%0d want 2/%0d", credits_o, state_o, S_READY);
    end
    start_i = 1'b1; cyc();
    m_credits = m_credits - COST;
    checks++;
    if (state_o !== S_PLAY || credits_o !== CREDIT_W'(m_credits) || cnt_clr_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++; $display("FAIL start_game: state=%0d credits=%0d clr=%0b busy=%0b want %0d/%0d/1/1",
                         state_o, credits_o, cnt_clr_o, busy_o, S_PLAY, m_credits);
    end
    // Tick during the clear cycle must not produce an add strobe
    tick_i = 1'b1; cyc(); tick_i = 1'b0; start_i = 1'b0;
    checks++;
    if (cnt_clr_o !== 1'b0 || cnt_add_o !== 1'b0) begin
      errors++; $display("FAIL clear_one_cycle: clr=%0b add=%0b want 0/0", cnt_clr_o, cnt_add_o);
    end
  endtask

  task automatic test_play_window();
    int a0;
    logic [4:0] exp_m;
    a0 = add_seen;
    for (int t = 1; t <= 10; t++) begin
      for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
        left_i  = 1'($urandom_range(0, 1));
        right_i = 1'($urandom_range(0, 1));
        #1;
        exp_m = {left_i & ~right_i, right_i & ~left_i, 3'b000};
        checks++;
        if (mvec !== exp_m) begin
          errors++; $display("FAIL play_joystick: l=%0b r=%0b motors=%b want %b", left_i, right_i, mvec, exp_m);
        end
        cyc();
      end
      left_i = 1'b0; right_i = 1'b0;
      tick_i = 1'b1; cyc(); tick_i = 1'b0;
      checks++;
      if (t < 10) begin
        if (state_o !== S_PLAY || cnt_add_o !== 1'b1) begin
          errors++; $display("FAIL tick_add: tick %0d state=%0d add=%0b want %0d/1", t, state_o, cnt_add_o, S_PLAY);
        end
      end else if (state_o !== S_DESCEND || cnt_add_o !== 1'b0) begin
        errors++; $display("FAIL timeout: state=%0d add=%0b want %0d/0", state_o, cnt_add_o, S_DESCEND);
      end
    end
    checks++;
    if (add_seen - a0 != 9) begin
      errors++; $display("FAIL add_count: got %0d want 9", add_seen - a0);
    end
  endtask

  task automatic test_full_cycle();
    int n;
    for (int i = 0; i < 5; i++) begin
      left_i = 1'($urandom_range(0, 1)); right_i = 1'($urandom_range(0, 1)); #1;
      checks++;
      if (state_o !== S_DESCEND || mvec !== 5'b00100) begin
        errors++; $display("FAIL descend: state=%0d motors=%b want %0d/00100", state_o, mvec, S_DESCEND);
      end
      cyc();
    end
    left_i = 1'b0; right_i = 1'b0;
    down_lim_i = 1'b1; cyc(); down_lim_i = 1'b0;
    n = 0;
    while (state_o === S_GRIP && n < 64) begin
      checks++;
      if (mvec !== 5'b00001) begin
        errors++; $display("FAIL grip_out: motors=%b want 00001", mvec);
      end
      cyc(); n++;
    end
    checks++;
    if (n != GRIP || state_o !== S_ASCEND) begin
      errors++; $display("FAIL grip_len: cycles=%0d state=%0d want %0d/%0d", n, state_o, GRIP, S_ASCEND);
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (state_o !== S_ASCEND || mvec !== 5'b00011) begin
        errors++; $display("FAIL ascend: state=%0d motors=%b want %0d/00011", state_o, mvec, S_ASCEND);
      end
      cyc();
    end
    up_lim_i = 1'b1; cyc(); up_lim_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (state_o !== S_HOME || mvec !== 5'b10001) begin
        errors++; $display("FAIL home: state=%0d motors=%b want %0d/10001", state_o, mvec, S_HOME);
      end
      cyc();
    end
    home_lim_i = 1'b1; cyc(); home_lim_i = 1'b0;
    start_i = 1'b1;
    n = 0;
    while (state_o === S_RELEASE && n < 64) begin
      checks++;
      if (mvec !== 5'b00000 || busy_o !== 1'b1) begin
        errors++; $display("FAIL release_out: motors=%b busy=%0b want 00000/1", mvec, busy_o);
      end
      cyc(); n++;
    end
    checks++;
    if (n != REL || state_o !== S_IDLE) begin
      errors++; $display("FAIL release_len: cycles=%0d state=%0d want %0d/%0d", n, state_o, REL, S_IDLE);
    end
  endtask

  task automatic test_back_to_back();
    cyc();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (state_o !== S_READY) begin
        errors++; $display("FAIL stale_start: state=%0d want %0d", state_o, S_READY);
      end
      cyc();
    end
    start_i = 1'b0; cyc(); start_i = 1'b1; cyc(); start_i = 1'b0;
    m_credits = m_credits - COST;
    checks++;
    if (state_o !== S_PLAY || credits_o !== CREDIT_W'(m_credits) || cnt_clr_o !== 1'b1) begin
      errors++; $display("FAIL second_game: state=%0d credits=%0d clr=%0b want %0d/%0d/1",
                         state_o, credits_o, cnt_clr_o, S_PLAY, m_credits);
    end
  endtask

  task automatic test_drop_tick();
    int a0, k, n;
    cyc();
    a0 = add_seen;
    k = $urandom_range(0, 5);
    for (int t = 0; t < k; t++) begin
      tick_i = 1'b1; cyc(); tick_i = 1'b0;
      checks++;
      if (cnt_add_o !== 1'b1) begin
        errors++; $display("FAIL drop_pre_tick: add=%0b want 1", cnt_add_o);
      end
      cyc();
    end
    left_i = 1'b1; right_i = 1'b1; #1;
    checks++;
    if (mvec !== 5'b00000) begin
      errors++; $display("FAIL both_joystick: motors=%b want 00000", mvec);
    end
    drop_i = 1'b1; tick_i = 1'b1; cyc();
    drop_i = 1'b0; tick_i = 1'b0; left_i = 1'b0; right_i = 1'b0;
    checks++;
    if (state_o !== S_DESCEND || cnt_add_o !== 1'b0) begin
      errors++; $display("FAIL drop_tick: state=%0d add=%0b want %0d/0", state_o, cnt_add_o, S_DESCEND);
    end
    cyc();
    checks++;
    if (add_seen - a0 != k) begin
      errors++; $display("FAIL drop_add_count: got %0d want %0d", add_seen - a0, k);
    end
    down_lim_i = 1'b1; cyc(); down_lim_i = 1'b0;
    n = 0;
    while (state_o === S_GRIP && n < 64) begin cyc(); n++; end
    up_lim_i = 1'b1; home_lim_i = 1'b1; cyc();
    checks++;
    if (state_o !== S_HOME) begin
      errors++; $display("FAIL home_entry: state=%0d want %0d", state_o, S_HOME);
    end
    cyc();
    up_lim_i = 1'b0; home_lim_i = 1'b0;
    checks++;
    if (state_o !== S_RELEASE) begin
      errors++; $display("FAIL home_one_cycle: state=%0d want %0d", state_o, S_RELEASE);
    end
    n = 0;
    while (state_o === S_RELEASE && n < 64) begin cyc(); n++; end
    repeat (3) cyc();
    checks++;
    if (state_o !== S_IDLE || credits_o !== CREDIT_W'(m_credits)) begin
      errors++; $display("FAIL idle_no_credit: state=%0d credits=%0d want %0d/%0d", state_o, credits_o, S_IDLE, m_credits);
    end
  endtask

  task automatic test_coin_start();
    int c, exp_c;
    for (int it = 0; it < 2; it++) begin
      apply_reset(1'b0);
      c = (it == 0) ? 1 : int'($urandom_range(1, CMAX));
      repeat (c) coin_pulse();
      coin_i = 1'b1; start_i = 1'b1; cyc();
      coin_i = 1'b0; start_i = 1'b0;
      exp_c = c + 1 - int'(COST);
      if (exp_c > CMAX) exp_c = CMAX;
      m_credits = exp_c;
      checks++;
      if (credits_o !== CREDIT_W'(exp_c) || state_o !== S_PLAY) begin
        errors++; $display("FAIL coin_with_start: c=%0d credits=%0d state=%0d want %0d/%0d",
                           c, credits_o, state_o, exp_c, S_PLAY);
      end
    end
  endtask

  task automatic test_reset_midgame();
    repeat (2) cyc();
    left_i = 1'b1;
    @(negedge clk);
    Reset = 1'b1; #1;
    checks++;
    if (state_o !== S_IDLE || credits_o !== '0 || {mvec, cnt_add_o, cnt_clr_o, busy_o} !== 8'b0) begin
      errors++; $display("FAIL async_reset: state=%0d credits=%0d outs=%b want 0/0/0",
                         state_o, credits_o, {mvec, cnt_add_o, cnt_clr_o, busy_o});
    end
    left_i = 1'b0;
    repeat (2) cyc();
    Reset = 1'b0; m_credits = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (cnt_clr_o !== 1'b0 || state_o !== S_IDLE) begin
        errors++; $display("FAIL post_reset: clr=%0b state=%0d want 0/%0d", cnt_clr_o, state_o, S_IDLE);
      end
    end
  endtask

  task automatic test_watchdog();
    int n;
    apply_reset(1'b0);
    coin_pulse();
    start_i = 1'b1; cyc(); start_i = 1'b0; m_credits = m_credits - COST;
    cyc();
    drop_i = 1'b1; cyc(); drop_i = 1'b0;
    checks++;
    if (state_o !== S_DESCEND) begin
      errors++; $display("FAIL wdog_descend: state=%0d want %0d", state_o, S_DESCEND);
    end
`ifdef CLAW_WDOG_EN
    n = 0;
    while (state_o === S_DESCEND && n < 200) begin cyc(); n++; end
    checks++;
    if (n != WDOG || state_o !== S_FAULT) begin
      errors++; $display("FAIL wdog_expire: cycles=%0d state=%0d want %0d/%0d", n, state_o, WDOG, S_FAULT);
    end
    checks++;
    if (fault_o !== 1'b1 || mvec !== 5'b00000 || busy_o !== 1'b1) begin
      errors++; $display("FAIL fault_outputs: fault=%0b motors=%b busy=%0b want 1/00000/1", fault_o, mvec, busy_o);
    end
    coin_pulse();
    down_lim_i = 1'b1; up_lim_i = 1'b1; home_lim_i = 1'b1;
    repeat (4) cyc();
    down_lim_i = 1'b0; up_lim_i = 1'b0; home_lim_i = 1'b0;
    checks++;
    if (state_o !== S_FAULT || credits_o !== CREDIT_W'(m_credits)) begin
      errors++; $display("FAIL fault_sticky: state=%0d credits=%0d want %0d/%0d", state_o, credits_o, S_FAULT, m_credits);
    end
    @(negedge clk); Reset = 1'b1; #1;
    checks++;
    if (state_o !== S_IDLE || fault_o !== 1'b0) begin
      errors++; $display("FAIL fault_reset: state=%0d fault=%0b want 0/0", state_o, fault_o);
    end
    cyc(); Reset = 1'b0; m_credits = 0;
`else
    n = 0;
    repeat (WDOG + 50) cyc();
    checks++;
    if (state_o !== S_DESCEND || fault_o !== 1'b0 || motor_down_o !== 1'b1) begin
      errors++; $display("FAIL no_wdog: state=%0d fault=%0b down=%0b want %0d/0/1", state_o, fault_o, motor_down_o, S_DESCEND);
    end
    apply_reset(1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_credits_random();
    test_saturation();
    test_start();
    test_play_window();
    test_full_cycle();
    test_back_to_back();
    test_drop_tick();
    test_coin_start();
    test_reset_midgame();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
